decim_iq_param: RTL and testbench
=================================

// Module: decim_iq_param
// PURPOSE
//   Parametrised I/Q decimator for the OFDM RX path, between the ADC front end (clk_40mhz domain) and the sync/FFT stages.
//   Runtime-selectable ratio 2^dec_log2 with two modes: pick (keep last sample of each period) or boxcar average (accumulate-and-dump, rounded).
//   Input is gated by a valid strobe. Output is a registered sample pair plus a one-cycle valid strobe.
//   A phase-realign input restarts the decimation period, so symbol timing recovery can align the output grid.
// PARAMETERS
//   DATA_W    14  signed sample width, I and Q, input and output
//   LOG2_MAX  3   largest supported log2 ratio (max ratio 8)
//   ACC_W     DATA_W+LOG2_MAX+1  per-channel accumulator width (derived, do not override)
// PORTS
//   clk_40mhz   in   1        system clock
//   rst         in   1        synchronous, active-high reset
//   in_valid    in   1        data_in_I/Q valid this cycle
//   data_in_I   in   DATA_W   signed I sample
//   data_in_Q   in   DATA_W   signed Q sample
//   dec_log2    in   3        ratio = 2^dec_log2; values > LOG2_MAX clamp to LOG2_MAX
//   mode        in   1        0 = pick, 1 = average
//   realign     in   1        restart period: discard partial accumulation
//   out_valid   out  1        one-cycle strobe per decimated output
//   data_out_I  out  DATA_W   signed decimated I, held between strobes
//   data_out_Q  out  DATA_W   signed decimated Q, held between strobes
// BEHAVIOUR
//   - One clock, clk_40mhz. Reset is synchronous and active-high: rst sampled high on a rising edge
//     clears the phase counter, both accumulators, data_out_I/Q and out_valid to 0.
//   - Period start: when the phase counter is 0 and in_valid=1, latch the effective ratio k=min(dec_log2,LOG2_MAX)
//     and mode into shadow registers. Changing dec_log2 or mode mid-period takes effect at the next period start.
//   - Each in_valid=1 cycle:
//       accumulate (sample 0 of a period loads instead of adds),
//       phase counter increments.
//     in_valid=0 cycles change nothing; out_valid=0.
//   - Period end: the 2^k-th valid sample. Counter wraps to 0.
//     The next cycle drives out_valid=1 with data_out_I/Q updated. Latency is exactly 1 clk after the last sample's edge.
//   - Pick mode: output = last valid sample of the period.
//   - Average mode: output = (sum + 2^(k-1)) >>> k, arithmetic shift.
//       Cannot overflow DATA_W, so no saturation logic is needed.
//       The sum itself is sign-extended to ACC_W, and no wrap is allowed.
//   - k=0: passthrough. Every valid input produces one output 1 clk later; both modes are identical.
//   - realign=1: phase counter and accumulators clear. No output is produced for the discarded partial period.
//       If in_valid=1 in the same cycle, that sample becomes sample 0 of a new period, and the shadow ratio/mode are re-latched.
//       If realign coincides with a period end, realign wins: no strobe.
//   - rst has priority over realign and in_valid.
//   - out_valid is never high on two consecutive cycles unless k=0.
// STRUCTURE
//   - Shared package decim_pkg:
//       localparam MODE_PICK=1'b0, MODE_AVG=1'b1;
//       default DATA_W / LOG2_MAX;
//       function clamp_log2().
//   - Sub-module decim_acc_ch: one channel of load/accumulate, round, shift and output register, instantiated for I and Q.
//   - The top level owns the phase counter, the shadow registers and the out_valid generation.
// TESTING
//   - Reset: drive rst=1 for 2 clks with random inputs.
//       Required: out_valid=0 and data_out=0 during and after reset, until the first completed period.
//   - Pick, dec_log2=2, in_valid=1 continuous, I=0,1,2,...
//       Required: out_valid on every 4th cycle, carrying I=3,7,11,...; Q checked the same way.
//   - Average, dec_log2=3, I=+8191 x8 then -8192 x8.
//       Required: outputs 8191 then -8192, with no overflow.
//   - Average, dec_log2=1, I={1,2} -> 2 (rounded 1.5); I={-1,-2} -> -1.
//   - Realign after 2 of 4 samples, with in_valid=1 on the realign cycle.
//       Required: the next strobe comes 4 valid samples later, i.e. the realign sample plus 3 more. No strobe for the partial period.
//   - Gaps and changes: in_valid toggling 1/0, dec_log2 changed 2->1 mid-period.
//       Required: the current period still counts 4 valid samples; the next period counts 2. dec_log2=7 behaves as 3.

Source files
------------

// File: rtl/decim_pkg.sv
// Shared constants and helpers for the I/Q decimator.
package decim_pkg;

  localparam int DATA_W_DEF   = 14;
  localparam int LOG2_MAX_DEF = 3;

  localparam logic MODE_PICK = 1'b0;
  localparam logic MODE_AVG  = 1'b1;

  // Requested ratios beyond what the accumulators were sized for saturate to the maximum.
  function automatic logic [2:0] clamp_log2(input logic [2:0] req, input logic [2:0] lmax);
    return (req > lmax) ? lmax : req;
  endfunction

endpackage

// File: rtl/decim_acc_ch.sv
// One decimator channel: load/accumulate, round-and-shift or pick, registered output.
module decim_acc_ch
  import decim_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ACC_W  = DATA_W_DEF + LOG2_MAX_DEF + 1
) (
  input  logic                     clk_40mhz,
  input  logic                     rst,
  input  logic                     en,
  input  logic                     first,
  input  logic                     clr,
  input  logic                     dump,
  input  logic                     avg,
  input  logic [2:0]               k,
  input  logic signed [DATA_W-1:0] din,
  output logic signed [DATA_W-1:0] dout
);

  logic signed [ACC_W-1:0] acc_reg;
  logic signed [ACC_W-1:0] din_ext;
  logic signed [ACC_W-1:0] sum_next;
  logic signed [ACC_W-1:0] rnd;
  logic signed [ACC_W-1:0] avg_val;

  always_comb begin
    din_ext  = {{(ACC_W-DATA_W){din[DATA_W-1]}}, din};
    sum_next = first ? din_ext : acc_reg + din_ext;
    rnd      = '0;
    if (k != 3'd0) begin
      rnd = ACC_W'(1) << (k - 3'd1);
    end
    // ACC_W leaves headroom for the full sum plus rounding term, so no wrap here.
    avg_val  = (sum_next + rnd) >>> k;
  end

  always_ff @(posedge clk_40mhz) begin
    if (rst) begin
      acc_reg <= '0;
      dout    <= '0;
    end else begin
      if (clr) begin
        acc_reg <= '0;
      end else if (en) begin
        acc_reg <= sum_next;
      end
      if (dump) begin
        dout <= avg ? avg_val[DATA_W-1:0] : din;
      end
    end
  end

endmodule

// File: rtl/decim_iq_param.sv
// I/Q decimator by 2^k with pick or rounded boxcar-average modes and period realign.
module decim_iq_param
  import decim_pkg::*;
#(
  parameter int DATA_W   = DATA_W_DEF,
  parameter int LOG2_MAX = LOG2_MAX_DEF
) (
  input  logic                     clk_40mhz,
  input  logic                     rst,
  input  logic                     in_valid,
  input  logic signed [DATA_W-1:0] data_in_I,
  input  logic signed [DATA_W-1:0] data_in_Q,
  input  logic [2:0]               dec_log2,
  input  logic                     mode,
  input  logic                     realign,
  output logic                     out_valid,
  output logic signed [DATA_W-1:0] data_out_I,
  output logic signed [DATA_W-1:0] data_out_Q
);

  localparam int ACC_W = DATA_W + LOG2_MAX + 1;
  localparam int PH_W  = (LOG2_MAX > 0) ? LOG2_MAX : 1;

  logic [PH_W-1:0] phase_reg;
  logic [2:0]      k_reg;
  logic            mode_reg;

  logic            start;
  logic [2:0]      k_eff;
  logic            mode_eff;
  logic [PH_W-1:0] phase_cur;
  logic [PH_W-1:0] last_idx;
  logic            last;
  logic            dump;
  logic            first;
  logic            clr;

  // Realign makes this cycle behave as a period start, so its sample re-latches the shadows.
  always_comb begin
    start     = realign || (phase_reg == '0);
    k_eff     = start ? clamp_log2(dec_log2, 3'(LOG2_MAX)) : k_reg;
    mode_eff  = start ? mode : mode_reg;
    phase_cur = realign ? '0 : phase_reg;
    last_idx  = PH_W'((8'd1 << k_eff) - 8'd1);
    last      = (phase_cur == last_idx);
    dump      = in_valid && last;
    first     = in_valid && start;
    clr       = realign && !in_valid;
  end

  always_ff @(posedge clk_40mhz) begin
    if (rst) begin
      phase_reg <= '0;
      k_reg     <= '0;
      mode_reg  <= MODE_PICK;
      out_valid <= 1'b0;
    end else begin
      out_valid <= dump;
      if (in_valid) begin
        if (start) begin
          k_reg    <= k_eff;
          mode_reg <= mode_eff;
        end
        phase_reg <= last ? '0 : phase_cur + PH_W'(1);
      end else if (realign) begin
        phase_reg <= '0;
      end
    end
  end

  logic signed [DATA_W-1:0] din_ch  [2];
  logic signed [DATA_W-1:0] dout_ch [2];

  assign din_ch[0]  = data_in_I;
  assign din_ch[1]  = data_in_Q;
  assign data_out_I = dout_ch[0];
  assign data_out_Q = dout_ch[1];

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_ch
      decim_acc_ch #(
        .DATA_W(DATA_W),
        .ACC_W (ACC_W)
      ) u_ch (
        .clk_40mhz(clk_40mhz),
        .rst      (rst),
        .en       (in_valid),
        .first    (first),
        .clr      (clr),
        .dump     (dump),
        .avg      (mode_eff == MODE_AVG),
        .k        (k_eff),
        .din      (din_ch[gi]),
        .dout     (dout_ch[gi])
      );
    end
  endgenerate

endmodule

// File: tb/tb_decim_iq_param.sv
// Scoreboard bench for decim_iq_param: directed scenarios plus randomized traffic against a period-level model.
module tb_decim_iq_param;

  logic              clk_40mhz = 1'b0;
  logic              rst = 1'b1;
  logic              in_valid = 1'b0;
  logic signed [13:0] data_in_I = '0;
  logic signed [13:0] data_in_Q = '0;
  logic [2:0]        dec_log2 = '0;
  logic              mode = 1'b0;
  logic              realign = 1'b0;
  logic              out_valid;
  logic signed [13:0] data_out_I;
  logic signed [13:0] data_out_Q;

  decim_iq_param dut (
    .clk_40mhz (clk_40mhz),
    .rst       (rst),
    .in_valid  (in_valid),
    .data_in_I (data_in_I),
    .data_in_Q (data_in_Q),
    .dec_log2  (dec_log2),
    .mode      (mode),
    .realign   (realign),
    .out_valid (out_valid),
    .data_out_I(data_out_I),
    .data_out_Q(data_out_Q)
  );

  always #5 clk_40mhz = ~clk_40mhz;

  typedef struct {int c; int i; int q;} exp_t;
  exp_t sb[$];

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  logic rst_seen;
  int held_i = 0;
  int held_q = 0;

  // Model state: samples collected in the current period plus its latched ratio/mode.
  int per_i[$];
  int per_q[$];
  int per_k = 0;
  logic per_m = 1'b0;

  always @(posedge clk_40mhz) begin
    cyc <= cyc + 1;
    rst_seen <= rst;
  end

  task automatic chk(input string name, input int act, input int req);
    n_cmp++;
    if (act != req) begin
      n_bad++;
      $display("FAIL %s cyc=%0d actual=%0d required=%0d", name, cyc, act, req);
    end
  endtask

  // Monitor: pops the scoreboard whenever the DUT strobes; otherwise checks held outputs.
  always @(negedge clk_40mhz) begin
    if (cyc >= 1) begin
      if (rst_seen) begin
        chk("rst_valid", int'(out_valid), 0);
        chk("rst_I", int'(data_out_I), 0);
        chk("rst_Q", int'(data_out_Q), 0);
        held_i = 0;
        held_q = 0;
      end else if (out_valid) begin
        if (sb.size() == 0) begin
          chk("unexpected_strobe", 1, 0);
        end else begin
          exp_t e;
          e = sb.pop_front();
          chk("strobe_cycle", cyc, e.c);
          chk("out_I", int'(data_out_I), e.i);
          chk("out_Q", int'(data_out_Q), e.q);
          $display("txn cyc=%0d I=%0d Q=%0d (exp %0d %0d)", cyc, data_out_I, data_out_Q, e.i, e.q);
          held_i = e.i;
          held_q = e.q;
        end
      end else begin
        chk("hold_I", int'(data_out_I), held_i);
        chk("hold_Q", int'(data_out_Q), held_q);
        if (sb.size() != 0 && sb[0].c <= cyc) begin
          exp_t e;
          e = sb.pop_front();
          chk("missed_strobe", cyc, e.c + 1000000);
        end
      end
    end
  end

  function automatic void model_step(input logic v, input int i, input int q,
                                     input int d, input logic m, input logic ra, input int c);
    int sum_i, sum_q, ri, rq, n;
    if (ra) begin
      per_i.delete();
      per_q.delete();
    end
    if (!v) return;
    if (per_i.size() == 0) begin
      per_k = (d > 3) ? 3 : d;
      per_m = m;
    end
    per_i.push_back(i);
    per_q.push_back(q);
    n = 1 << per_k;
    if (per_i.size() == n) begin
      if (per_m == 1'b0) begin
        ri = i;
        rq = q;
      end else begin
        sum_i = 0;
        sum_q = 0;
        foreach (per_i[j]) begin
          sum_i += per_i[j];
          sum_q += per_q[j];
        end
        if (per_k > 0) begin
          sum_i += 1 << (per_k - 1);
          sum_q += 1 << (per_k - 1);
        end
        ri = sum_i >>> per_k;
        rq = sum_q >>> per_k;
      end
      sb.push_back('{c: c + 1, i: ri, q: rq});
      per_i.delete();
      per_q.delete();
    end
  endfunction

  task automatic drive(input logic r, input logic v, input int i, input int q,
                       input int d, input logic m, input logic ra);
    @(posedge clk_40mhz);
    #1;
    rst       = r;
    in_valid  = v;
    data_in_I = i[13:0];
    data_in_Q = q[13:0];
    dec_log2  = d[2:0];
    mode      = m;
    realign   = ra;
    if (r) begin
      per_i.delete();
      per_q.delete();
    end else begin
      model_step(v, i, q, d, m, ra, cyc);
    end
  endtask

  function automatic int rnd_s();
    return int'($urandom_range(0, 16383)) - 8192;
  endfunction

  initial begin
    data_in_I = 14'(rnd_s());
    data_in_Q = 14'(rnd_s());
    in_valid  = 1'b1;
    mode      = 1'b1;
    dec_log2  = 3'd1;

    // Reset held with random inputs.
    for (int n = 0; n < 2; n++) drive(1'b1, 1'($urandom_range(0, 1)), rnd_s(), rnd_s(), 1, 1'b0, 1'($urandom_range(0, 1)));
    drive(1'b0, 1'b0, 0, 0, 0, 1'b0, 1'b0);
    drive(1'b0, 1'b0, 0, 0, 0, 1'b0, 1'b0);

    // Pick, ratio 4, ramp input.
    for (int n = 0; n < 16; n++) drive(1'b0, 1'b1, n, 1000 - n, 2, 1'b0, 1'b0);

    // Average, ratio 8, full-scale positive then negative.
    for (int n = 0; n < 8; n++) drive(1'b0, 1'b1, 8191, -8192, 3, 1'b1, 1'b0);
    for (int n = 0; n < 8; n++) drive(1'b0, 1'b1, -8192, 8191, 3, 1'b1, 1'b0);

    // Average, ratio 2, rounding of half values.
    drive(1'b0, 1'b1, 1, -1, 1, 1'b1, 1'b0);
    drive(1'b0, 1'b1, 2, -2, 1, 1'b1, 1'b0);
    drive(1'b0, 1'b1, -1, 1, 1, 1'b1, 1'b0);
    drive(1'b0, 1'b1, -2, 2, 1, 1'b1, 1'b0);

    // Realign after 2 of 4 samples, valid on the realign cycle.
    drive(1'b0, 1'b1, 10, 20, 2, 1'b0, 1'b0);
    drive(1'b0, 1'b1, 11, 21, 2, 1'b0, 1'b0);
    drive(1'b0, 1'b1, 12, 22, 2, 1'b0, 1'b1);
    for (int n = 0; n < 3; n++) drive(1'b0, 1'b1, 13 + n, 23 + n, 2, 1'b0, 1'b0);

    // Gaps, ratio changed 2->1 mid-period, then dec_log2=7.
    drive(1'b0, 1'b1, 30, 40, 2, 1'b0, 1'b0);
    for (int n = 1; n < 8; n++) drive(1'b0, 1'(n % 2 == 0), 30 + n, 40 + n, 1, 1'b0, 1'b0);
    for (int n = 0; n < 2; n++) drive(1'b0, 1'b1, 50 + n, 60 + n, 1, 1'b0, 1'b0);
    for (int n = 0; n < 8; n++) drive(1'b0, 1'b1, 100 * n, -100 * n, 7, 1'b1, 1'b0);

    // Randomized traffic.
    for (int n = 0; n < 800; n++) begin
      drive(1'b0, 1'($urandom_range(0, 3) != 0), rnd_s(), rnd_s(),
            int'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
            1'($urandom_range(0, 40) == 0));
    end

    for (int n = 0; n < 4; n++) drive(1'b0, 1'b0, 0, 0, 0, 1'b0, 1'b0);
    chk("scoreboard_drained", sb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
